// File: rtl/filter_pkg.sv
// Shared types, window-depth constants and the pre-scaling helper for the
// multi-channel moving-average filter.
package filter_pkg;

  localparam int SAMPLE_WIDTH    = 24;
  localparam int DFLT_LOG2_DEPTH = 3;
  localparam int DEPTH           = 1 << DFLT_LOG2_DEPTH;
  localparam int SCALE_W         = 64;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  // Wide enough for any legal sample width; callers sign-extend in and truncate out.
  function automatic logic signed [SCALE_W-1:0] scale_sample(
    input logic signed [SCALE_W-1:0] s,
    input int unsigned               shift
  );
    return s >>> shift;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// One channel's circular window buffer: asynchronous read of the slot about to
// be overwritten, so the same-cycle read returns the old contents.
module sample_delay_line #(
  parameter int WIDTH      = 24,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [LOG2_DEPTH-1:0] addr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int LINE_DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0] mem_q [LINE_DEPTH];

  assign rd_data = mem_q[addr];

  // No reset: stale contents are masked by the fill counter in the parent.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/moving_avg_filter.sv
// Multi-channel boxcar filter: pre-scaled samples feed a running sum per channel,
// with a shared write pointer, warm-up fill counter, flush and bypass.
module moving_avg_filter #(
  parameter int WIDTH      = filter_pkg::SAMPLE_WIDTH,
  parameter int LOG2_DEPTH = filter_pkg::DFLT_LOG2_DEPTH,
  parameter int CHANNELS   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [CHANNELS*WIDTH-1:0] datain,
  input  logic                      bypass,
  input  logic                      flush,
  output logic [CHANNELS*WIDTH-1:0] dataout,
  output logic                      valid_out,
  output logic                      primed
);

  import filter_pkg::*;

  localparam int                  WIN_DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_FULL = (LOG2_DEPTH + 1)'(WIN_DEPTH);

  logic [LOG2_DEPTH-1:0]             ptr_q, ptr_d;
  logic [LOG2_DEPTH:0]               fill_q, fill_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    sum_q, sum_d;
  logic [CHANNELS*WIDTH-1:0]         dataout_q, dataout_d;
  logic                              valid_out_q, valid_out_d;

  logic                              primed_now;
  logic                              accept;
  logic [CHANNELS-1:0][WIDTH-1:0]    scaled;
  logic [CHANNELS-1:0][WIDTH-1:0]    rd_data;
  logic [CHANNELS-1:0][WIDTH-1:0]    oldest;
  logic [CHANNELS-1:0][WIDTH-1:0]    new_sum;
  logic [CHANNELS-1:0][WIDTH-1:0]    dout_sel;

  assign primed_now = (fill_q == FILL_FULL);
  assign accept     = valid_in & ~flush;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign scaled[gi] = WIDTH'(scale_sample(
                            SCALE_W'(signed'(datain[gi*WIDTH +: WIDTH])),
                            LOG2_DEPTH));

      sample_delay_line #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
      ) u_line (
        .clock   (clock),
        .wr_en   (accept),
        .addr    (ptr_q),
        .wr_data (scaled[gi]),
        .rd_data (rd_data[gi])
      );

      // Until the window is full the slot being overwritten never entered the sum.
      assign oldest[gi]   = primed_now ? rd_data[gi] : '0;
      assign new_sum[gi]  = sum_q[gi] + scaled[gi] - oldest[gi];
      assign dout_sel[gi] = bypass ? datain[gi*WIDTH +: WIDTH] : new_sum[gi];
    end
  endgenerate

  always_comb begin
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    sum_d       = sum_q;
    dataout_d   = dataout_q;
    valid_out_d = 1'b0;
    if (flush) begin
      ptr_d     = '0;
      fill_d    = '0;
      sum_d     = '0;
      dataout_d = '0;
    end else if (valid_in) begin
      ptr_d       = ptr_q + 1'b1;
      fill_d      = primed_now ? fill_q : fill_q + 1'b1;
      sum_d       = new_sum;
      dataout_d   = dout_sel;
      valid_out_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      dataout_q   <= '0;
      valid_out_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      dataout_q   <= dataout_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign dataout   = dataout_q;
  assign valid_out = valid_out_q;
  assign primed    = primed_now;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter: a window model pushes expected outputs
// to a scoreboard queue, popped and checked one cycle after each accepted sample.
module tb_moving_avg_filter;

  import filter_pkg::*;

  localparam int W  = 24;
  localparam int L  = 3;
  localparam int CH = 2;
  localparam int D  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              valid_in = 1'b0;
  logic              bypass = 1'b0;
  logic              flush = 1'b0;
  logic [CH*W-1:0]   datain = '0;
  logic [CH*W-1:0]   dataout;
  logic              valid_out;
  logic              primed;

  moving_avg_filter #(.WIDTH(W), .LOG2_DEPTH(L), .CHANNELS(CH)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (valid_in),
    .datain    (datain),
    .bypass    (bypass),
    .flush     (flush),
    .dataout   (dataout),
    .valid_out (valid_out),
    .primed    (primed)
  );

  always #5 clock = ~clock;

  typedef struct {
    int d0;
    int d1;
    bit pr;
  } exp_t;

  exp_t sb[$];
  int   win0[$];
  int   win1[$];
  int   n_acc    = 0;
  int   pass_cnt = 0;
  int   total    = 0;
  int   sent     = 0;
  int   vo_seen  = 0;
  int   last0    = 0;
  int   last1    = 0;
  sample_t probe;

  always @(posedge clock) begin
    if (valid_out === 1'b1) vo_seen++;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    win0.delete();
    win1.delete();
    n_acc = 0;
    last0 = 0;
    last1 = 0;
  endtask

  task automatic model_accept(input int a, input int b, input bit byp);
    exp_t e;
    int   s0, s1;
    win0.push_back(a >>> L);
    win1.push_back(b >>> L);
    if (win0.size() > D) void'(win0.pop_front());
    if (win1.size() > D) void'(win1.pop_front());
    if (n_acc < D) n_acc++;
    s0 = 0;
    s1 = 0;
    foreach (win0[i]) s0 += win0[i];
    foreach (win1[i]) s1 += win1[i];
    e.d0 = byp ? a : s0;
    e.d1 = byp ? b : s1;
    e.pr = (n_acc == D);
    sb.push_back(e);
  endtask

  task automatic send(input string tag, input int a, input int b, input bit byp = 1'b0);
    exp_t e;
    @(negedge clock);
    datain   = {W'(b), W'(a)};
    valid_in = 1'b1;
    bypass   = byp;
    model_accept(a, b, byp);
    sent++;
    @(posedge clock);
    #1;
    valid_in = 1'b0;
    e = sb.pop_front();
    chk({tag, "_ch0"}, $signed(dataout[W-1:0]), e.d0);
    chk({tag, "_ch1"}, $signed(dataout[2*W-1:W]), e.d1);
    chk({tag, "_vout"}, 32'(valid_out), 32'd1);
    chk({tag, "_primed"}, 32'(primed), 32'(e.pr));
    $display("sample %s in=(%0d,%0d) out=(%0d,%0d) primed=%0b", tag, a, b,
             $signed(dataout[W-1:0]), $signed(dataout[2*W-1:W]), primed);
    last0 = e.d0;
    last1 = e.d1;
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) begin
      @(negedge clock);
      valid_in = 1'b0;
      datain   = {W'(-12345), W'(54321)};
      @(posedge clock);
      #1;
      chk({tag, "_vout"}, 32'(valid_out), 32'd0);
      chk({tag, "_hold0"}, $signed(dataout[W-1:0]), last0);
      chk({tag, "_hold1"}, $signed(dataout[2*W-1:W]), last1);
    end
    $display("idle %s cycles=%0d out=(%0d,%0d)", tag, n,
             $signed(dataout[W-1:0]), $signed(dataout[2*W-1:W]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ch0"}, $signed(dataout[W-1:0]), 0);
    chk({tag, "_ch1"}, $signed(dataout[2*W-1:W]), 0);
    chk({tag, "_vout"}, 32'(valid_out), 32'd0);
    chk({tag, "_primed"}, 32'(primed), 32'd0);
  endtask

  task automatic do_flush(input string tag, input bit with_valid);
    @(negedge clock);
    flush    = 1'b1;
    valid_in = with_valid;
    datain   = {W'(-800), W'(800)};
    @(posedge clock);
    #1;
    flush    = 1'b0;
    valid_in = 1'b0;
    model_clear();
    check_zero(tag);
    $display("flush %s valid_in=%0b", tag, with_valid);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_zero(tag);
    @(negedge clock);
    reset = 1'b1;
    $display("reset %s", tag);
  endtask

  initial begin
    probe = '0;
    repeat (2) @(negedge clock);
    check_zero("por");
    reset = 1'b1;
    $display("reset por released");

    // Step response
    for (int i = 0; i < 10; i++) send($sformatf("step%0d", i), 800, -800);

    // Bursts with gaps
    idle("gap_a", 3);
    send("burst0", 240, -56);
    send("burst1", 1000, 3);
    idle("gap_b", 2);
    send("burst2", -4000, 4000);
    idle("gap_c", 3);
    send("burst3", 17, -17);
    idle("gap_d", 1);

    // Window slide, exercises pointer wrap twice
    do_flush("fl_slide", 1'b0);
    for (int i = 0; i < 8; i++) send($sformatf("up%0d", i), 8000, -8000);
    for (int i = 0; i < 8; i++) send($sformatf("down%0d", i), 0, 0);

    // Truncation toward minus infinity
    do_flush("fl_trunc", 1'b0);
    for (int i = 0; i < 9; i++) send($sformatf("trunc%0d", i), -1, 7);

    // Bypass after priming, then resume averaging
    do_flush("fl_byp", 1'b0);
    for (int i = 0; i < 8; i++) send($sformatf("prime%0d", i), 800, -800);
    send("byp0", 1600, -1600, 1'b1);
    send("byp1", -333, 4444, 1'b1);
    send("nobyp", 800, -800);

    // Mid-stream reset
    do_flush("fl_rst", 1'b0);
    for (int i = 0; i < 5; i++) send($sformatf("pre_rst%0d", i), 800, -800);
    idle("pre_rst_gap", 1);
    do_reset("mid_rst");
    send("post_rst", 800, -800);

    // Flush colliding with valid_in drops that sample
    for (int i = 0; i < 5; i++) send($sformatf("pre_fl%0d", i), 2400, -2400);
    do_flush("fl_collide", 1'b1);
    send("post_fl", 800, -800);

    idle("tail", 1);
    chk("vout_count", vo_seen, sent);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/moving_avg_filter.md
# moving_avg_filter

Parametrised, multi-channel moving-average (boxcar FIR) filter for the audio path between the codec read interface and the codec write interface. Each accepted input sample is pre-scaled by 1/DEPTH with an arithmetic shift and written into a circular delay line. A running sum is updated by adding the new scaled sample and subtracting the scaled sample leaving the window. Successor to the fixed 24-bit single-channel filter: adds configurable width, depth and channel count, a valid handshake, warm-up tracking, a synchronous flush and a bypass mode.

## Interface
- WIDTH, 24, sample width in bits (two's complement).
- LOG2_DEPTH, 3, log2 of window length; DEPTH = 2**LOG2_DEPTH; legal range 1–10.
- CHANNELS, 2, independent channels (for example left and right); legal range 1–8.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  one-cycle strobe: datain holds one new sample per channel.
- datain  in  CHANNELS*WIDTH  packed samples; channel c occupies bits [c*WIDTH +: WIDTH].
- bypass  in  1  1 = dataout carries the registered raw input instead of the average.
- flush  in  1  synchronous clear of sums, fill count and valid_out.
- dataout  out  CHANNELS*WIDTH  filtered (or bypassed) samples, same packing as datain.
- valid_out  out  1  one-cycle strobe: dataout has just been updated.
- primed  out  1  high once DEPTH samples have been accepted since the last reset or flush.

## Operation
- Scaling: scaled = datain_c >>> LOG2_DEPTH, arithmetic shift (rounds toward −∞). All arithmetic is WIDTH bits wide. The sum of DEPTH scaled values fits in WIDTH bits, so the sum never overflows.
- Delay line: one DEPTH-entry circular buffer per channel, sharing a single LOG2_DEPTH-bit write pointer. The pointer increments by 1 on each accepted sample and wraps from DEPTH−1 to 0.
- Per accepted sample:
  - oldest = buf[ptr] when primed, else 0.
  - sum ← sum + scaled − oldest.
  - buf[ptr] ← scaled; ptr ← ptr + 1.
- Because oldest is forced to 0 until primed, buffer RAM needs no reset. Buffer contents are don't-care after reset or flush.
- Fill counter:
  - Width LOG2_DEPTH+1; increments on each accepted sample while below DEPTH, then saturates.
  - primed = (fill == DEPTH).
- Output mux (registered): dataout_c ← bypass ? datain_c : new sum_c.
  - The filter state updates regardless of bypass, so leaving bypass produces no transient.
- flush has priority over valid_in when both are high in the same cycle:
  - sum = 0, fill = 0, ptr = 0, valid_out = 0, dataout = 0.
  - The sample presented that cycle is dropped.
- Cycles with valid_in low leave all state and dataout unchanged.

## Timing
- Reset (asynchronous, active-low): dataout = 0, valid_out = 0, primed = 0; internally sum = 0, fill = 0, ptr = 0. Reset asserted mid-stream discards the window; the next accepted sample is treated as sample 0.
- Latency is 1 cycle:
  - valid_in high at edge k makes dataout and valid_out valid after edge k.
  - valid_out is high for exactly one cycle per accepted sample.
- primed rises after the edge that accepts the DEPTH-th sample, together with that sample's valid_out.
- Back-to-back valid_in (every cycle) is supported at full throughput. The buffer read of buf[ptr] and the write of buf[ptr] happen in the same cycle: the read returns the old value (read-before-write). Use a register array or a read-first RAM.
- bypass and flush are sampled on the rising edge; no setup beyond normal timing.

## Structure
- Package filter_pkg holds:
  - sample_t (logic signed [WIDTH-1:0]) as a parametrised typedef, or via a WIDTH localparam default.
  - function scale_sample() performing the arithmetic shift.
  - localparam DEPTH derived from LOG2_DEPTH.
- Sub-module sample_delay_line #(WIDTH, LOG2_DEPTH):
  - One circular buffer with read-before-write behaviour.
  - Instantiated CHANNELS times in a generate loop.
  - Pointer and fill logic stay in the top level and are shared by all channels.

## Test plan
All scenarios use WIDTH=24, LOG2_DEPTH=3, CHANNELS=2.
- Step: 10 accepted samples of 800 on ch0 and −800 on ch1 → ch0 outputs 100, 200, …, 800, then holds 800; ch1 mirrors with −100 … −800; primed rises with the 8th valid_out.
- Truncation: constant input −1 → scaled −1 each sample → ch output reaches −8 when primed; constant input 7 → output stays 0.
- Window slide: 8 samples of 8000, then 8 samples of 0 → output steps down by 1000 per sample from 8000 to 0; ptr wraps with no glitch.
- Gaps and throughput: valid_in in bursts with idle cycles between → dataout unchanged across gaps; totals match the gap-free run; valid_out count equals valid_in count.
- Bypass: assert bypass after priming on 800 → dataout equals raw datain one cycle later; deassert → the next output is the correct window average (no restart).
- Reset and flush mid-operation: after 5 samples, pulse reset low (or flush high with valid_in high) → all outputs 0, primed 0; the next sample of 800 outputs 100.
